fpu_result_stage: RTL
=====================

# fpu_result_stage

Buffered writeback stage directly downstream of the floating-point multiplier. It accepts each combinational result and its exception flags through a valid/ready handshake and holds them in a small FIFO. It canonicalises NaN results and presents them to the consumer through a second valid/ready handshake. On commit it accumulates sticky IEEE exception flags and a saturating invalid-operation count.

## Interface
- `exp`, 8, exponent field width
- `frac`, 23, fraction field width
- `width`, exp+frac+1, result word width
- `DEPTH`, 4, FIFO entries; power of two, ≥2
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `in_valid`  in  1  producer has a result
- `in_ready`  out  1  stage can accept
- `in_r`  in  width  result word {sign, exponent, fraction}
- `in_flags`  in  5  {invalid, divzero, overflow, underflow, inexact}, bit 4..0
- `out_valid`  out  1  head entry available
- `out_ready`  in  1  consumer takes head
- `out_r`  out  width  head result, NaN-canonicalised
- `out_flags`  out  5  head entry flags
- `fflags`  out  5  sticky accumulated flags of committed results
- `fflags_clr`  in  1  clear sticky flags
- `nv_count`  out  16  committed results with invalid set, saturating
- `occupancy`  out  log2(DEPTH)+1  entries held

## Operation
- Push: `in_valid && in_ready` writes {canon(in_r), in_flags} at the write pointer. The write pointer increments modulo DEPTH.
- Pop (commit): `out_valid && out_ready` advances the read pointer modulo DEPTH. The same edge updates `fflags` and `nv_count` from the popped entry.
- canon(x): if exponent is all ones and fraction is nonzero, the result is {0, all-ones exponent, 1, zeros} (0x7FC00000 for defaults). Otherwise x passes through unchanged. Infinity is never altered.
- `in_ready = (occupancy != DEPTH)`. This is a pure function of registered state, with no combinational path from `out_ready`.
- `out_valid = (occupancy != 0)`. `out_r`/`out_flags` are driven from the head entry.
- Occupancy: push only → +1; pop only → −1; push and pop together → unchanged.
- Full: `in_ready=0`. A push is refused even if a pop happens in the same cycle. The producer must hold `in_r`/`in_flags` stable while `in_valid && !in_ready`.
- Empty: `out_valid=0`, and `out_ready` has no effect. Data is never bypassed; an entry is visible only from the cycle after its push.
- Sticky flags:
  - Next value = (`fflags_clr` ? 0 : `fflags`) | (pop ? popped flags : 0).
  - A clear and a pop in the same cycle leave exactly the popped flags.
- `nv_count`: increments by 1 on a pop whose flags[4]=1 and holds at 0xFFFF. `fflags_clr` does not reset it; only `rst` does.
- Pointers are log2(DEPTH) bits wide and wrap naturally. Full and empty are distinguished by the occupancy counter, not by pointer equality.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_r`=0, `out_flags`=0, `fflags`=0, `nv_count`=0, `occupancy`=0. Both pointers are 0.
- Asserting `rst` mid-operation discards all entries immediately, independent of `clk`. Storage contents need no reset, but `out_r`/`out_flags` must read 0 while `occupancy`=0.
- Latency: a result pushed at edge N has `out_valid`=1 after edge N, so it can be popped at edge N+1.
- Throughput: one push and one pop per cycle sustained while 0 < occupancy < DEPTH.
- `fflags`/`nv_count` change only at the edge where the pop occurs.

## Test plan
- Single pass: push `in_r`=0x40400000, `in_flags`=0 with `out_ready`=0.
  - Next cycle: `out_valid`=1, `out_r`=0x40400000, `occupancy`=1.
  - Then raise `out_ready`: `out_valid`=0 and `fflags`=0.
- NaN canonicalisation:
  - Push 0xFFC00001 with flags 0x10 → `out_r`=0x7FC00000. After the pop, `fflags`=0x10 and `nv_count`=1.
  - Push 0xFF800000 → `out_r`=0xFF800000 (infinity, unchanged).
- Full/wrap:
  - Push 4 results with `out_ready`=0 → `in_ready`=0, `occupancy`=4.
  - A 5th push held with `in_valid`=1 plus one pop in the same cycle → the push is refused and `occupancy`=3.
  - Next cycle the push is accepted. Then pop all 4 and check FIFO order, including across the pointer wrap.
- Sticky flags:
  - Commit flags 0x01, then 0x04 → `fflags`=0x05.
  - Assert `fflags_clr` in the same cycle as a pop with flags 0x10 → `fflags`=0x10.
  - `fflags_clr` with no pop → 0x00.
- Simultaneous push/pop at occupancy 2 for 10 cycles → `occupancy` stays 2 and outputs come out in order.
- Saturation and reset:
  - Force `nv_count` to 0xFFFE and commit 3 invalid results → 0xFFFF.
  - Assert `rst` asynchronously between edges with `occupancy`=3 → all outputs return to their reset values immediately.

Source files
------------

// File: rtl/fpu_result_stage.sv
// Writeback buffer behind the FP multiplier: NaN-canonicalising FIFO with
// valid/ready on both sides, sticky exception flags and a saturating invalid count.
module fpu_result_stage #(
  parameter int exp   = 8,
  parameter int frac  = 23,
  parameter int width = exp + frac + 1,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [width-1:0]         in_r,
  input  logic [4:0]               in_flags,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [width-1:0]         out_r,
  output logic [4:0]               out_flags,
  output logic [4:0]               fflags,
  input  logic                     fflags_clr,
  output logic [15:0]              nv_count,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] OCC_FULL = (PW+1)'(DEPTH);

  logic [width-1:0] r_mem [DEPTH];
  logic [4:0]       f_mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push;
  logic             pop;
  logic [width-1:0] in_canon;
  logic [4:0]       head_flags;

  // Quiet-NaN canonical form; infinities (zero fraction) pass untouched.
  always_comb begin
    in_canon = in_r;
    if ((&in_r[width-2 -: exp]) && (|in_r[frac-1:0]))
      in_canon = {1'b0, {exp{1'b1}}, 1'b1, {(frac-1){1'b0}}};
  end

  assign in_ready   = (occupancy != OCC_FULL);
  assign out_valid  = (occupancy != '0);
  assign push       = in_valid && in_ready;
  assign pop        = out_valid && out_ready;
  assign head_flags = f_mem[rd_ptr];

  // Storage is deliberately unreset; the head is masked while empty instead.
  assign out_r     = out_valid ? r_mem[rd_ptr] : '0;
  assign out_flags = out_valid ? head_flags    : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      r_mem[wr_ptr] <= in_canon;
      f_mem[wr_ptr] <= in_flags;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fflags   <= '0;
      nv_count <= '0;
    end else begin
      fflags <= (fflags_clr ? 5'd0 : fflags) | (pop ? head_flags : 5'd0);
      if (pop && head_flags[4] && (nv_count != 16'hFFFF))
        nv_count <= nv_count + 16'd1;
    end
  end

endmodule
